multi_rate_enable_gen: RTL and testbench

- Parametrised successor to the single-rate clock divider.
- Generates NUM_CH independent active-low, one-cycle enable strobes from one clock, each at a runtime-programmable divisor.
- Feeds display-mux, debounce and sampling logic that need several slow enables from one fast clock.
- Adds global run/sync control and a divisor-write handshake with glitch-free (wrap-aligned) divisor update.

---
 rtl/clkdiv_pkg.sv | 9 +
 rtl/multi_rate_enable_gen_if.sv | 14 +
 rtl/clkdiv_channel.sv | 81 ++++++++
 rtl/multi_rate_enable_gen.sv | 44 ++++
 tb/tb_multi_rate_enable_gen.sv | 114 +++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: channel state type, default divisor and index-width helper
// shared by multi_rate_enable_gen and its channels.
package clkdiv_pkg;
  typedef enum logic [1:0] {CH_OFF, CH_RUN, CH_PEND} ch_state_t;
  localparam int DEFAULT_DIV_C = 800;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_rate_enable_gen_if.sv
// multi_rate_enable_gen_if: divisor-write request/acknowledge bundle.
interface multi_rate_enable_gen_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                          div_wr;
  logic [ch_idx_w(NUM_CH)-1:0]   div_ch;
  logic [CNT_W-1:0]              div_val;
  logic                          div_ack;
  modport master (output div_wr, div_ch, div_val, input div_ack);
  modport slave (input div_wr, div_ch, div_val, output div_ack);
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one enable channel (counter, shadow divisor, OFF/RUN/PEND FSM).
// CLKDIV_PHASE_STAGGER_EN makes restarts load the channel index instead of 0.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int IDX         = 0,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic             sync_clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_val_i,
  output logic             en_n_o
);
`ifdef CLKDIV_PHASE_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif
  localparam logic [CNT_W-1:0] IDX_C = CNT_W'(IDX);
  localparam logic [CNT_W-1:0] DEF_C = CNT_W'(DEFAULT_DIV);
  localparam ch_state_t RST_ST = (DEF_C == '0) ? CH_OFF : CH_RUN;

  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
    return (STAGGER && IDX_C < d) ? IDX_C : '0;
  endfunction

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shd_q, shd_d;
  logic             en_n_q, en_n_d, wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_ST;
      cnt_q   <= load_val(DEF_C);
      div_q   <= DEF_C;
      shd_q   <= '0;
      en_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shd_q   <= shd_d;
      en_n_q  <= en_n_d;
    end
  end

  // div_q - 1 is only meaningful when div_q != 0, which the guard ensures
  always_comb begin
    wrap    = run_i && (div_q != '0) && (cnt_q == div_q - 1'b1);
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    shd_d   = wr_i ? wr_val_i : shd_q;
    en_n_d  = !(wrap && !sync_clr_i);
    if (sync_clr_i) begin
      div_d   = wr_i ? wr_val_i : (state_q == CH_PEND ? shd_q : div_q);
      cnt_d   = load_val(div_d);
      state_d = (div_d == '0) ? CH_OFF : CH_RUN;
    end else if (state_q == CH_OFF) begin
      if (wr_i) begin
        div_d   = wr_val_i;
        cnt_d   = '0;
        state_d = (wr_val_i == '0) ? CH_OFF : CH_RUN;
      end
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(run_i);
      if (wrap && state_q == CH_PEND) begin
        div_d   = shd_d;
        state_d = (shd_d == '0) ? CH_OFF : CH_RUN;
      end else if (wr_i) begin
        state_d = CH_PEND;
      end
    end
  end

  assign en_n_o = en_n_q;
endmodule

// File: rtl/multi_rate_enable_gen.sv
// multi_rate_enable_gen: NUM_CH active-low enable strobes with runtime divisors,
// wrap-aligned divisor update and run/sync control (see CLKDIV_PHASE_STAGGER_EN).
module multi_rate_enable_gen
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      sync_clr,
  multi_rate_enable_gen_if.slave    wr_if,
  output logic [NUM_CH-1:0]         enable_n
);
  logic acc, ack_q, ack_d;

  assign acc   = wr_if.div_wr && (int'(wr_if.div_ch) < NUM_CH);
  assign ack_d = acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_q <= 1'b0;
    else          ack_q <= ack_d;
  end

  assign wr_if.div_ack = ack_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .IDX         (c),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .run_i      (run),
      .sync_clr_i (sync_clr),
      .wr_i       (acc && int'(wr_if.div_ch) == c),
      .wr_val_i   (wr_if.div_val),
      .en_n_o     (enable_n[c])
    );
  end
endmodule

// File: tb/tb_multi_rate_enable_gen.sv
// tb_multi_rate_enable_gen: directed vector table plus async-reset sequence,
// NUM_CH=4, CNT_W=8, DEFAULT_DIV=4.
module tb_multi_rate_enable_gen;
  typedef struct {
    bit         run;
    bit         clr;
    bit         wr;
    logic [1:0] ch;
    logic [7:0] val;
    logic [3:0] en;
    bit         ack;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n, run, sync_clr;
  logic [3:0] enable_n;
  int         nvec = 0;
  int         nfail = 0;
  vec_t       tbl[$];

  multi_rate_enable_gen_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  multi_rate_enable_gen #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .sync_clr (sync_clr),
    .wr_if    (bus.slave),
    .enable_n (enable_n)
  );

  always #5 clk = ~clk;

  task automatic add(input bit r, input bit c, input bit w, input int ch, input int val,
                     input logic [3:0] en, input bit ack);
    vec_t v;
    v.run = r; v.clr = c; v.wr = w; v.ch = 2'(ch); v.val = 8'(val); v.en = en; v.ack = ack;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [3:0] en);
    add(1, 0, 0, 0, 0, en, 0);
  endtask

  task automatic check(input string name, input logic [3:0] en, input logic ack);
    nvec++;
    if (enable_n !== en || bus.div_ack !== ack) begin
      nfail++;
      $display("FAIL %s: enable_n=%b div_ack=%b, expected enable_n=%b div_ack=%b",
               name, enable_n, bus.div_ack, en, ack);
    end
  endtask

  initial begin
    // default divisor 4: strobes after edges 4 and 8
    idle(4'hF); idle(4'hF); idle(4'hF); idle(4'h0);
    idle(4'hF); idle(4'hF); idle(4'hF); idle(4'h0);
    idle(4'hF);
    add(1, 0, 1, 2, 3, 4'hF, 1);                         // 10: ch2=3 at cnt=1
    idle(4'hF); idle(4'h0); idle(4'hF); idle(4'hF);
    idle(4'hB); idle(4'h4); idle(4'hF); idle(4'hB);
    idle(4'hF); idle(4'h4); idle(4'hB);
    add(1, 0, 1, 1, 0, 4'hF, 1);                         // 22: ch1=0
    idle(4'hF); idle(4'h0); idle(4'hF); idle(4'hF);
    idle(4'hB); idle(4'h6); idle(4'hF); idle(4'hB);
    idle(4'hF); idle(4'h6); idle(4'hB);
    add(1, 0, 1, 1, 5, 4'hF, 1);                         // 34: ch1=5 from OFF
    idle(4'hF); idle(4'h2); idle(4'hF); idle(4'hF);
    idle(4'h9); idle(4'h6); idle(4'hF); idle(4'hB);
    idle(4'hF); idle(4'h4);
    add(1, 0, 1, 0, 1, 4'hB, 1);                         // 45: ch0=1
    idle(4'hF); idle(4'hF); idle(4'h2); idle(4'hC);
    idle(4'hE); idle(4'hA); idle(4'h6);
    add(0, 0, 0, 0, 0, 4'hF, 0);                         // 53: run low
    add(0, 0, 0, 0, 0, 4'hF, 0);
    idle(4'hE); idle(4'h8); idle(4'hE); idle(4'h6);
    idle(4'hA); idle(4'hE); idle(4'hC);
    add(1, 1, 0, 0, 0, 4'hF, 0);                         // 62: sync_clr on ch3 wrap
    idle(4'hE); idle(4'hE); idle(4'hA); idle(4'h6);
    idle(4'hC); idle(4'hA);
    add(1, 1, 1, 3, 2, 4'hF, 1);                         // 69: sync_clr + ch3=2
    idle(4'hE); idle(4'h6); idle(4'hA); idle(4'h6);
    idle(4'hC);
    add(1, 0, 1, 2, 2, 4'h2, 1);                         // 75: ch2=2 pending
    add(1, 1, 0, 0, 0, 4'hF, 0);                         // 76: sync_clr applies shadow
    idle(4'hE); idle(4'h2); idle(4'hE); idle(4'h2);
    idle(4'hC);
    add(1, 0, 1, 1, 7, 4'h2, 1);                         // 82: ch1=7 pending
    reset_n = 1'b0; run = 1'b0; sync_clr = 1'b0;
    bus.div_wr = 1'b0; bus.div_ch = '0; bus.div_val = '0;
    repeat (2) @(posedge clk);
    #1 check("reset", 4'hF, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    foreach (tbl[i]) begin
      run = tbl[i].run; sync_clr = tbl[i].clr;
      bus.div_wr = tbl[i].wr; bus.div_ch = tbl[i].ch; bus.div_val = tbl[i].val;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i + 1), tbl[i].en, tbl[i].ack);
    end
    // asynchronous reset while a strobe and an ack are visible
    #2 reset_n = 1'b0;
    bus.div_wr = 1'b0; sync_clr = 1'b0;
    #1 check("async_reset", 4'hF, 1'b0);
    @(posedge clk);
    #1 check("in_reset", 4'hF, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1 check($sformatf("post_reset%0d", k), (k % 4 == 0) ? 4'h0 : 4'hF, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
